// File: rtl/hdr_field_arbiter.sv
// hdr_field_arbiter: shares the header bit assembler's single field input
// between NUM_REQ header-field producers. A winner owns the assembler for a
// whole packet header, which ends on an accepted field with hdr_last set.
// Fields pass through combinationally, and there is one bubble between packets.
//
// Build option: define HDR_FIELD_ARB_FIXED_PRIO_EN for fixed priority, where
// the lowest index wins. The default build is round-robin.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters
// LOCK  | grant_q owner forwards fields until its last field is accepted
module hdr_field_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BIT_CNT_W  = 6,
    parameter int HDR_DATA_W = 32,
    parameter int PKT_CNT_W  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ-1:0]              req_last_i,
    input  logic [NUM_REQ-1:0]              req_insert_zero_i,
    input  logic [NUM_REQ-1:0]              req_insert_ones_i,
    input  logic [NUM_REQ*BIT_CNT_W-1:0]    req_bit_cnt_i,
    input  logic [NUM_REQ*HDR_DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic                            valid_o,
    output logic                            hdr_last_o,
    output logic                            insert_zero_o,
    output logic                            insert_ones_o,
    output logic [BIT_CNT_W-1:0]            bit_cnt_o,
    output logic [HDR_DATA_W-1:0]           hdr_data_o,
    input  logic                            hdr_ready_i,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic                            busy_o,
    output logic                            err_o,
    output logic [PKT_CNT_W-1:0]            pkt_cnt_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [PKT_CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic                   err_q, err_d;
    logic [IDX_W-1:0]       own_idx;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       cand;
    logic                   win_found;
    logic                   xfer;
`ifndef HDR_FIELD_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]       ptr_q, ptr_d;
`endif

    // Binary index of the current owner, decoded from the one-hot grant.
    always_comb begin
        own_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) own_idx = IDX_W'(i);
        end
    end

    // Winner search: first valid requester in priority order.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef HDR_FIELD_ARB_FIXED_PRIO_EN
            cand = IDX_W'(i);
`else
            // Start just past the last completed owner so every requester gets a turn.
            cand = IDX_W'((int'(ptr_q) + 1 + i) % NUM_REQ);
`endif
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Zero-latency field mux from the owner's slice; everything is 0 in IDLE.
    always_comb begin
        req_ready_o   = '0;
        valid_o       = 1'b0;
        hdr_last_o    = 1'b0;
        insert_zero_o = 1'b0;
        insert_ones_o = 1'b0;
        bit_cnt_o     = '0;
        hdr_data_o    = '0;
        if (state_q == S_LOCK) begin
            req_ready_o[own_idx] = hdr_ready_i;
            valid_o       = req_valid_i[own_idx];
            hdr_last_o    = req_last_i[own_idx];
            insert_zero_o = req_insert_zero_i[own_idx];
            insert_ones_o = req_insert_ones_i[own_idx];
            bit_cnt_o     = req_bit_cnt_i[own_idx*BIT_CNT_W +: BIT_CNT_W];
            hdr_data_o    = req_data_i[own_idx*HDR_DATA_W +: HDR_DATA_W];
        end
    end

    assign xfer      = valid_o & hdr_ready_i;
    assign grant_o   = grant_q;
    assign busy_o    = (state_q == S_LOCK);
    assign err_o     = err_q;
    assign pkt_cnt_o = pkt_cnt_q;

    // Next-state logic: grant in IDLE, release on an accepted last field.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        pkt_cnt_d = pkt_cnt_q;
        err_d     = err_q;
`ifndef HDR_FIELD_ARB_FIXED_PRIO_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d = '0;
                    grant_d[win_idx] = 1'b1;
                    state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                if (xfer) begin
                    // Conflicting insert flags are flagged but still forwarded.
                    if (insert_zero_o && insert_ones_o) err_d = 1'b1;
                    if (hdr_last_o) begin
                        state_d   = S_IDLE;
                        grant_d   = '0;
                        pkt_cnt_d = pkt_cnt_q + 1'b1;
`ifndef HDR_FIELD_ARB_FIXED_PRIO_EN
                        ptr_d     = own_idx;
`endif
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any partial header.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            pkt_cnt_q <= '0;
            err_q     <= 1'b0;
`ifndef HDR_FIELD_ARB_FIXED_PRIO_EN
            ptr_q     <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_q     <= err_d;
`ifndef HDR_FIELD_ARB_FIXED_PRIO_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

endmodule
